// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Readback monitor for a multiplexed common-anode seven-segment display bus.
// The anode and cathode lines are synchronized and combined into one sample S.
// A digit slot is captured once S has selected exactly one anode and stayed
// unchanged for STABLE_CYCLES consecutive samples. The cathode pattern is then
// decoded back to a hex nibble and stored for that slot.
//
// Parameters
//   NUM_DIGITS     number of anode lines / digit slots (2..8)
//   STABLE_CYCLES  identical consecutive samples needed before capture (1..255)
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   an           anode enables, active-low (an[i]=0 selects digit i)
//   seg          cathodes {a,b,c,d,e,f,g}, seg[6]=a, active-low
//   clear        synchronous clear of digits/digit_valid/bad_seg
//   digits       decoded hex, digit i at [4i+3:4i]
//   digit_valid  digit i holds a decoded value
//   bad_seg      sticky flag: an undecodable pattern was captured on digit i
//   upd_stb      one-cycle pulse for every accepted capture
//   upd_idx      digit index belonging to the current upd_stb
//
// Build option
//   SEG7_BLANK_EN  when defined, the all-off pattern 1111111 is a legal blank:
//                  capturing it clears digit_valid[i] instead of setting
//                  bad_seg[i]. When undefined, 1111111 is undecodable.
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_DIGITS-1:0]         an,
  input  logic [6:0]                    seg,
  input  logic                          clear,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic [NUM_DIGITS-1:0]         bad_seg,
  output logic                          upd_stb,
  output logic [$clog2(NUM_DIGITS)-1:0] upd_idx
);

  localparam int         IDX_W      = $clog2(NUM_DIGITS);
  localparam int         S_W        = NUM_DIGITS + 7;
  localparam logic [7:0] STABLE_TGT = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Flops reset to all-ones, i.e. an idle bus with every
  // anode off, so nothing can look like a selected digit right after reset.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] an_meta_reg;
  logic [NUM_DIGITS-1:0] an_sync_reg;
  logic [6:0]            seg_meta_reg;
  logic [6:0]            seg_sync_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_meta_reg  <= '1;
      an_sync_reg  <= '1;
      seg_meta_reg <= '1;
      seg_sync_reg <= '1;
    end else begin
      an_meta_reg  <= an;
      an_sync_reg  <= an_meta_reg;
      seg_meta_reg <= seg;
      seg_sync_reg <= seg_meta_reg;
    end
  end

  logic [S_W-1:0] sample;
  assign sample = {an_sync_reg, seg_sync_reg};

  // ---------------------------------------------------------------------------
  // Anode inspection: count the active (low) anodes and remember which one.
  // The index is only meaningful when exactly one anode is active.
  // ---------------------------------------------------------------------------
  logic [7:0]       zero_cnt;
  logic [IDX_W-1:0] sel_idx;
  logic             selecting;

  always_comb begin
    zero_cnt = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_sync_reg[i]) begin
        zero_cnt = zero_cnt + 8'd1;
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign selecting = (zero_cnt == 8'd1);

  // ---------------------------------------------------------------------------
  // Cathode decode: inverse of the encoder's active-low abcdefg table.
  // Result is {match, value}.
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b0000001: res = {1'b1, 4'h0};
      7'b1001111: res = {1'b1, 4'h1};
      7'b0010010: res = {1'b1, 4'h2};
      7'b0000110: res = {1'b1, 4'h3};
      7'b1001100: res = {1'b1, 4'h4};
      7'b0100100: res = {1'b1, 4'h5};
      7'b0100000: res = {1'b1, 4'h6};
      7'b0001111: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0000100: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b1100000: res = {1'b1, 4'hB};
      7'b0110001: res = {1'b1, 4'hC};
      7'b1000010: res = {1'b1, 4'hD};
      7'b0110000: res = {1'b1, 4'hE};
      7'b0111000: res = {1'b1, 4'hF};
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [4:0] dec_res;
  logic       dec_ok;
  logic [3:0] dec_val;
  logic       is_blank;

  assign dec_res = decode_seg(seg_sync_reg);
  assign dec_ok  = dec_res[4];
  assign dec_val = dec_res[3:0];

`ifdef SEG7_BLANK_EN
  assign is_blank = (seg_sync_reg == 7'b1111111);
`else
  assign is_blank = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Qualification FSM. The next-state/capture decision is computed here and
  // all FSM state plus the strobe outputs are registered in one block below.
  // ---------------------------------------------------------------------------
  state_t         state_reg;
  state_t         state_next;
  logic [7:0]     count_reg;
  logic [7:0]     count_next;
  logic [S_W-1:0] s_prev_reg;
  logic           same;
  logic           capture;
  logic           upd_stb_reg;
  logic [IDX_W-1:0] upd_idx_reg;

  assign same = (sample == s_prev_reg);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        count_next = '0;
        if (selecting) begin
          state_next = ST_QUALIFY;
          count_next = 8'd1;
        end
      end

      ST_QUALIFY: begin
        if (!selecting) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (same) begin
          count_next = (count_reg >= STABLE_TGT) ? STABLE_TGT : count_reg + 8'd1;
        end else begin
          count_next = 8'd1;
        end
      end

      ST_HELD: begin
        if (!selecting) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (!same) begin
          state_next = ST_QUALIFY;
          count_next = 8'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase

    // Capture on the edge where the run length reaches the target. Checking
    // after the case also covers entry into QUALIFY when STABLE_CYCLES is 1.
    if ((state_next == ST_QUALIFY) && (count_next == STABLE_TGT)) begin
      capture    = 1'b1;
      state_next = ST_HELD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      s_prev_reg  <= '1;
      upd_stb_reg <= 1'b0;
      upd_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      s_prev_reg  <= sample;
      // clear discards a coincident capture, so its strobe is dropped too
      upd_stb_reg <= capture && !clear;
      if (capture && !clear) begin
        upd_idx_reg <= sel_idx;
      end
    end
  end

  assign upd_stb = upd_stb_reg;
  assign upd_idx = upd_idx_reg;

  // ---------------------------------------------------------------------------
  // Per-digit capture registers.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] value_reg;
      logic       valid_reg;
      logic       bad_reg;
      logic       hit;

      assign hit = capture && (sel_idx == IDX_W'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          value_reg <= '0;
          valid_reg <= 1'b0;
          bad_reg   <= 1'b0;
        end else if (clear) begin
          value_reg <= '0;
          valid_reg <= 1'b0;
          bad_reg   <= 1'b0;
        end else if (hit) begin
          if (is_blank) begin
            // blank display: the slot no longer shows a value
            valid_reg <= 1'b0;
          end else if (dec_ok) begin
            value_reg <= dec_val;
            valid_reg <= 1'b1;
          end else begin
            // sticky until clear; the last good value is kept
            bad_reg <= 1'b1;
          end
        end
      end

      assign digits[4*gi +: 4] = value_reg;
      assign digit_valid[gi]   = valid_reg;
      assign bad_seg[gi]       = bad_reg;
    end
  endgenerate

endmodule
